lsu_mem_req: RTL and testbench

- Load/store initiator between the pipeline MEM stage and the data-memory port. It drives the same rd_ctrl/wr_ctrl/addr/wdata/rdata interface that the data memory answers.
- Accepts one load or store per handshake and issues it to memory.
- Aligned accesses go out as a single beat. Misaligned half/word accesses are split into sequential byte beats.
- Returns sign- or zero-extended load data with a one-cycle response pulse.

---
 rtl/lsu_mem_req_if.sv | 35 +++
 rtl/lsu_mem_req.sv | 157 +++++++++++++++
 tb/tb_lsu_mem_req.sv | 274 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/lsu_mem_req_if.sv
// Bundle between the MEM-stage pipeline, the load/store initiator and the data memory.
// master = pipeline plus memory side; slave = lsu_mem_req.
interface lsu_mem_req_if #(
  parameter int XLEN = 32
);
  logic            req_valid;
  logic            req_ready;
  logic            req_we;
  logic [1:0]      req_size;
  logic            req_unsigned;
  logic [XLEN-1:0] req_addr;
  logic [XLEN-1:0] req_wdata;
  logic            resp_valid;
  logic [XLEN-1:0] resp_rdata;
  logic            resp_err;
  logic [2:0]      data_sram_rd_ctrl;
  logic [1:0]      data_sram_wr_ctrl;
  logic [XLEN-1:0] data_sram_addr;
  logic [XLEN-1:0] data_sram_wdata;
  logic [XLEN-1:0] data_sram_rdata;

  modport master (
    output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
    input  req_ready, resp_valid, resp_rdata, resp_err,
    input  data_sram_rd_ctrl, data_sram_wr_ctrl, data_sram_addr, data_sram_wdata,
    output data_sram_rdata
  );

  modport slave (
    input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
    output req_ready, resp_valid, resp_rdata, resp_err,
    output data_sram_rd_ctrl, data_sram_wr_ctrl, data_sram_addr, data_sram_wdata,
    input  data_sram_rdata
  );
endinterface

// File: rtl/lsu_mem_req.sv
// Load/store initiator: issues one request to the data memory as a single native beat,
// or as sequential byte beats when misaligned, and returns extended load data.
module lsu_mem_req #(
  parameter int XLEN           = 32,
  parameter bit MISALIGN_SPLIT = 1'b1
) (
  input  logic          clk,
  input  logic          rst_n,
  lsu_mem_req_if.slave  bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ACCESS,
    S_SPLIT,
    S_RESP,
    S_ERR
  } state_t;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_ILL  = 2'b11;

  state_t          state_q, state_d;
  logic [XLEN-1:0] addr_q;
  logic [XLEN-1:0] wdata_q;
  logic            we_q;
  logic [1:0]      size_q;
  logic            uns_q;
  logic            split_q;
  logic [1:0]      beat_q;
  logic [XLEN-1:0] cap_q;

  logic            handshake;
  logic            misaligned;
  logic            last_beat;
  logic [XLEN-1:0] split_ext;

  assign handshake  = bus.req_valid && (state_q == S_IDLE);
  assign misaligned = ((bus.req_size == SZ_HALF) && bus.req_addr[0]) ||
                      ((bus.req_size == SZ_WORD) && (bus.req_addr[1:0] != 2'b00));
  assign last_beat  = (beat_q == ((size_q == SZ_HALF) ? 2'd1 : 2'd3));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (handshake) begin
          if ((bus.req_size == SZ_ILL) || (misaligned && !MISALIGN_SPLIT))
            state_d = S_ERR;
          else if (misaligned)
            state_d = S_SPLIT;
          else
            state_d = S_ACCESS;
        end
      end
      S_ACCESS: state_d = S_RESP;
      S_SPLIT:  if (last_beat) state_d = S_RESP;
      S_RESP:   state_d = S_IDLE;
      S_ERR:    state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Request fields are frozen at the handshake so the memory side never sees req_* directly.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q  <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
      size_q  <= '0;
      uns_q   <= 1'b0;
      split_q <= 1'b0;
      beat_q  <= '0;
      cap_q   <= '0;
    end else begin
      if (handshake) begin
        addr_q  <= bus.req_addr;
        wdata_q <= bus.req_wdata;
        we_q    <= bus.req_we;
        size_q  <= bus.req_size;
        uns_q   <= bus.req_unsigned;
        split_q <= misaligned;
        beat_q  <= '0;
        cap_q   <= '0;
      end else if (state_q == S_ACCESS) begin
        if (!we_q) cap_q <= bus.data_sram_rdata;
      end else if (state_q == S_SPLIT) begin
        if (!we_q) cap_q[{beat_q, 3'b000} +: 8] <= bus.data_sram_rdata[7:0];
        beat_q <= beat_q + 2'd1;
      end
    end
  end

  // Split loads assemble raw bytes, so extension happens here rather than in memory.
  always_comb begin
    split_ext = cap_q;
    if (size_q == SZ_HALF)
      split_ext = {{(XLEN-16){~uns_q & cap_q[15]}}, cap_q[15:0]};
  end

  always_comb begin
    bus.req_ready         = 1'b0;
    bus.resp_valid        = 1'b0;
    bus.resp_err          = 1'b0;
    bus.resp_rdata        = '0;
    bus.data_sram_rd_ctrl = 3'b000;
    bus.data_sram_wr_ctrl = 2'b00;
    bus.data_sram_addr    = '0;
    bus.data_sram_wdata   = '0;
    unique case (state_q)
      S_IDLE: bus.req_ready = 1'b1;
      S_ACCESS: begin
        bus.data_sram_addr  = addr_q;
        bus.data_sram_wdata = wdata_q;
        if (we_q) begin
          unique case (size_q)
            SZ_BYTE: bus.data_sram_wr_ctrl = 2'b01;
            SZ_HALF: bus.data_sram_wr_ctrl = 2'b10;
            default: bus.data_sram_wr_ctrl = 2'b11;
          endcase
        end else begin
          unique case (size_q)
            SZ_BYTE: bus.data_sram_rd_ctrl = uns_q ? 3'b010 : 3'b001;
            SZ_HALF: bus.data_sram_rd_ctrl = uns_q ? 3'b100 : 3'b011;
            default: bus.data_sram_rd_ctrl = 3'b101;
          endcase
        end
      end
      S_SPLIT: begin
        bus.data_sram_addr = addr_q + {{(XLEN-2){1'b0}}, beat_q};
        if (we_q) begin
          bus.data_sram_wr_ctrl = 2'b01;
          bus.data_sram_wdata   = wdata_q >> {beat_q, 3'b000};
        end else begin
          bus.data_sram_rd_ctrl = 3'b010;
        end
      end
      S_RESP: begin
        bus.resp_valid = 1'b1;
        if (!we_q) bus.resp_rdata = split_q ? split_ext : cap_q;
      end
      S_ERR: begin
        bus.resp_valid = 1'b1;
        bus.resp_err   = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_lsu_mem_req.sv
// Directed bench for lsu_mem_req: a byte-array data memory behind the splitting instance,
// plus a second instance with splitting disabled against a constant read port.
module tb_lsu_mem_req;
  localparam int XLEN = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  lsu_mem_req_if #(.XLEN(XLEN)) bus ();
  lsu_mem_req_if #(.XLEN(XLEN)) bus_ns ();

  lsu_mem_req #(.XLEN(XLEN), .MISALIGN_SPLIT(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );
  lsu_mem_req #(.XLEN(XLEN), .MISALIGN_SPLIT(1'b0)) dut_ns (
    .clk(clk), .rst_n(rst_n), .bus(bus_ns)
  );

  assign bus_ns.data_sram_rdata = 32'h1357_9BDF;

  // Data memory model: 4 KiB little-endian, address aliased to 12 bits.
  logic [7:0]  mem [0:4095];
  logic        mem_clr, pl_en;
  logic [11:0] pl_addr, ma;
  logic [7:0]  pl_data, b0, b1, b2, b3;
  logic [31:0] mw;

  assign ma = bus.data_sram_addr[11:0];
  assign mw = bus.data_sram_wdata;

  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < 4096; i++) mem[i] <= 8'h00;
    end else if (pl_en) begin
      mem[pl_addr] <= pl_data;
    end else begin
      case (bus.data_sram_wr_ctrl)
        2'b01: mem[ma] <= mw[7:0];
        2'b10: begin mem[ma] <= mw[7:0]; mem[ma+12'd1] <= mw[15:8]; end
        2'b11: begin
          mem[ma] <= mw[7:0];         mem[ma+12'd1] <= mw[15:8];
          mem[ma+12'd2] <= mw[23:16]; mem[ma+12'd3] <= mw[31:24];
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    b0 = mem[ma]; b1 = mem[ma+12'd1]; b2 = mem[ma+12'd2]; b3 = mem[ma+12'd3];
    case (bus.data_sram_rd_ctrl)
      3'b001:  bus.data_sram_rdata = {{24{b0[7]}}, b0};
      3'b010:  bus.data_sram_rdata = {24'h0, b0};
      3'b011:  bus.data_sram_rdata = {{16{b1[7]}}, b1, b0};
      3'b100:  bus.data_sram_rdata = {16'h0, b1, b0};
      3'b101:  bus.data_sram_rdata = {b3, b2, b1, b0};
      default: bus.data_sram_rdata = 32'h0;
    endcase
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  task automatic pl(input logic [11:0] a, input logic [7:0] d);
    pl_addr = a; pl_data = d; pl_en = 1'b1;
    @(negedge clk);
    pl_en = 1'b0;
  endtask

  logic [2:0]  bt_rd   [8];
  logic [1:0]  bt_wr   [8];
  logic [31:0] bt_addr [8];
  logic [31:0] bt_wd   [8];
  int          nbeats;

  // Called at a negedge with the chosen instance idle; returns at a negedge with it idle again.
  task automatic do_req(input bit sel, input logic we, input logic [1:0] sz, input logic uns,
                        input logic [31:0] a, input logic [31:0] wd,
                        output int lat, output logic [31:0] rd, output logic err);
    logic [2:0] rdc; logic [1:0] wrc; logic [31:0] sa, sw, rr; logic rv, re;
    nbeats = 0; lat = -1; rd = '0; err = 1'b0;
    if (sel) begin
      bus_ns.req_valid = 1'b1; bus_ns.req_we = we; bus_ns.req_size = sz;
      bus_ns.req_unsigned = uns; bus_ns.req_addr = a; bus_ns.req_wdata = wd;
    end else begin
      bus.req_valid = 1'b1; bus.req_we = we; bus.req_size = sz;
      bus.req_unsigned = uns; bus.req_addr = a; bus.req_wdata = wd;
    end
    @(posedge clk);
    for (int c = 1; c <= 12 && lat < 0; c++) begin
      @(negedge clk);
      bus.req_valid = 1'b0; bus_ns.req_valid = 1'b0;
      if (sel) begin
        rdc = bus_ns.data_sram_rd_ctrl; wrc = bus_ns.data_sram_wr_ctrl;
        sa = bus_ns.data_sram_addr; sw = bus_ns.data_sram_wdata;
        rv = bus_ns.resp_valid; rr = bus_ns.resp_rdata; re = bus_ns.resp_err;
      end else begin
        rdc = bus.data_sram_rd_ctrl; wrc = bus.data_sram_wr_ctrl;
        sa = bus.data_sram_addr; sw = bus.data_sram_wdata;
        rv = bus.resp_valid; rr = bus.resp_rdata; re = bus.resp_err;
      end
      if (rdc != 3'b000 || wrc != 2'b00) begin
        if (nbeats < 8) begin
          bt_rd[nbeats] = rdc; bt_wr[nbeats] = wrc; bt_addr[nbeats] = sa; bt_wd[nbeats] = sw;
        end
        nbeats++;
      end
      if (rv) begin lat = c; rd = rr; err = re; end
    end
    @(negedge clk);
  endtask

  typedef struct {
    logic        we;
    logic [1:0]  sz;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [31:0] exp_rd;
    logic        exp_err;
    int          exp_lat;
    int          exp_beats;
    logic [2:0]  exp_rd0;
    logic [1:0]  exp_wr0;
  } vec_t;

  vec_t vt [20];

  initial begin
    int lat; logic [31:0] rd; logic err;
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat; logic [31:0] rd; logic err;
    vt[0]  = '{1'b0, 2'b10, 1'b0, 32'h0000_0100, 32'h0, 32'h8899_AABB, 1'b0, 2, 1, 3'b101, 2'b00};
    vt[1]  = '{1'b0, 2'b00, 1'b0, 32'h0000_0203, 32'h0, 32'hFFFF_FFF0, 1'b0, 2, 1, 3'b001, 2'b00};
    vt[2]  = '{1'b0, 2'b00, 1'b1, 32'h0000_0203, 32'h0, 32'h0000_00F0, 1'b0, 2, 1, 3'b010, 2'b00};
    vt[3]  = '{1'b0, 2'b01, 1'b0, 32'h0000_0102, 32'h0, 32'hFFFF_8899, 1'b0, 2, 1, 3'b011, 2'b00};
    vt[4]  = '{1'b0, 2'b01, 1'b1, 32'h0000_0102, 32'h0, 32'h0000_8899, 1'b0, 2, 1, 3'b100, 2'b00};
    vt[5]  = '{1'b0, 2'b10, 1'b0, 32'h0000_0101, 32'h0, 32'h7788_99AA, 1'b0, 5, 4, 3'b010, 2'b00};
    vt[6]  = '{1'b0, 2'b01, 1'b0, 32'h0000_0203, 32'h0, 32'hFFFF_C3F0, 1'b0, 3, 2, 3'b010, 2'b00};
    vt[7]  = '{1'b0, 2'b01, 1'b1, 32'h0000_0203, 32'h0, 32'h0000_C3F0, 1'b0, 3, 2, 3'b010, 2'b00};
    vt[8]  = '{1'b0, 2'b01, 1'b0, 32'hFFFF_FFFF, 32'h0, 32'h0000_1280, 1'b0, 3, 2, 3'b010, 2'b00};
    vt[9]  = '{1'b0, 2'b11, 1'b0, 32'h0000_0100, 32'h0, 32'h0,         1'b1, 1, 0, 3'b000, 2'b00};
    vt[10] = '{1'b1, 2'b10, 1'b0, 32'h0000_0300, 32'hCAFE_F00D, 32'h0, 1'b0, 2, 1, 3'b000, 2'b11};
    vt[11] = '{1'b0, 2'b10, 1'b0, 32'h0000_0300, 32'h0, 32'hCAFE_F00D, 1'b0, 2, 1, 3'b101, 2'b00};
    vt[12] = '{1'b1, 2'b00, 1'b0, 32'h0000_0305, 32'h1234_565A, 32'h0, 1'b0, 2, 1, 3'b000, 2'b01};
    vt[13] = '{1'b0, 2'b00, 1'b1, 32'h0000_0305, 32'h0, 32'h0000_005A, 1'b0, 2, 1, 3'b010, 2'b00};
    vt[14] = '{1'b1, 2'b01, 1'b0, 32'h0000_0307, 32'h0000_BEEF, 32'h0, 1'b0, 3, 2, 3'b000, 2'b01};
    vt[15] = '{1'b0, 2'b01, 1'b1, 32'h0000_0307, 32'h0, 32'h0000_BEEF, 1'b0, 3, 2, 3'b010, 2'b00};
    vt[16] = '{1'b0, 2'b01, 1'b0, 32'h0000_0307, 32'h0, 32'hFFFF_BEEF, 1'b0, 3, 2, 3'b010, 2'b00};
    vt[17] = '{1'b1, 2'b01, 1'b0, 32'h0000_030A, 32'h7777_A5A5, 32'h0, 1'b0, 2, 1, 3'b000, 2'b10};
    vt[18] = '{1'b0, 2'b10, 1'b0, 32'h0000_0308, 32'h0, 32'hA5A5_00BE, 1'b0, 2, 1, 3'b101, 2'b00};
    vt[19] = '{1'b1, 2'b11, 1'b0, 32'h0000_0310, 32'hFFFF_FFFF, 32'h0, 1'b1, 1, 0, 3'b000, 2'b00};

    bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_size = '0; bus.req_unsigned = 1'b0;
    bus.req_addr = '0; bus.req_wdata = '0;
    bus_ns.req_valid = 1'b0; bus_ns.req_we = 1'b0; bus_ns.req_size = '0;
    bus_ns.req_unsigned = 1'b0; bus_ns.req_addr = '0; bus_ns.req_wdata = '0;
    pl_en = 1'b0; pl_addr = '0; pl_data = '0; mem_clr = 1'b1;
    rst_n = 1'b0;
    @(negedge clk);
    mem_clr = 1'b0;

    chk("rst_req_ready", {31'b0, bus.req_ready}, 32'h1);
    chk("rst_resp_valid", {31'b0, bus.resp_valid}, 32'h0);
    chk("rst_resp_err", {31'b0, bus.resp_err}, 32'h0);
    chk("rst_resp_rdata", bus.resp_rdata, 32'h0);
    chk("rst_ctrl", {27'b0, bus.data_sram_rd_ctrl, bus.data_sram_wr_ctrl}, 32'h0);
    chk("rst_addr", bus.data_sram_addr, 32'h0);
    chk("rst_wdata", bus.data_sram_wdata, 32'h0);

    pl(12'h100, 8'hBB); pl(12'h101, 8'hAA); pl(12'h102, 8'h99); pl(12'h103, 8'h88);
    pl(12'h104, 8'h77); pl(12'h203, 8'hF0); pl(12'h204, 8'hC3);
    pl(12'hFFF, 8'h80); pl(12'h000, 8'h12);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 20; i++) begin
      do_req(1'b0, vt[i].we, vt[i].sz, vt[i].uns, vt[i].addr, vt[i].wd, lat, rd, err);
      chk($sformatf("v%0d_rdata", i), rd, vt[i].exp_rd);
      chk($sformatf("v%0d_err", i), {31'b0, err}, {31'b0, vt[i].exp_err});
      chk($sformatf("v%0d_latency", i), lat, vt[i].exp_lat);
      chk($sformatf("v%0d_beats", i), nbeats, vt[i].exp_beats);
      if (vt[i].exp_beats > 0 && nbeats > 0) begin
        chk($sformatf("v%0d_rd_ctrl0", i), {29'b0, bt_rd[0]}, {29'b0, vt[i].exp_rd0});
        chk($sformatf("v%0d_wr_ctrl0", i), {30'b0, bt_wr[0]}, {30'b0, vt[i].exp_wr0});
        chk($sformatf("v%0d_addr0", i), bt_addr[0], vt[i].addr);
      end
    end

    // Split store, every beat inspected, then read back across both words.
    do_req(1'b0, 1'b1, 2'b10, 1'b0, 32'h0000_0101, 32'h1122_3344, lat, rd, err);
    chk("sw_split_latency", lat, 5);
    chk("sw_split_beats", nbeats, 4);
    for (int b = 0; b < 4 && b < nbeats; b++) begin
      chk($sformatf("sw_split_b%0d_wr", b), {30'b0, bt_wr[b]}, 32'h1);
      chk($sformatf("sw_split_b%0d_rd", b), {29'b0, bt_rd[b]}, 32'h0);
      chk($sformatf("sw_split_b%0d_addr", b), bt_addr[b], 32'h101 + b);
      chk($sformatf("sw_split_b%0d_wdata", b), bt_wd[b], 32'h1122_3344 >> (8 * b));
    end
    chk("sw_split_rdata", rd, 32'h0);
    do_req(1'b0, 1'b0, 2'b10, 1'b0, 32'h0000_0100, 32'h0, lat, rd, err);
    chk("sw_split_rb_lo", rd, 32'h2233_44BB);
    do_req(1'b0, 1'b0, 2'b10, 1'b0, 32'h0000_0104, 32'h0, lat, rd, err);
    chk("sw_split_rb_hi", rd, 32'h0000_0011);

    // Splitting disabled: misaligned and illegal-size requests error out without memory traffic.
    do_req(1'b1, 1'b0, 2'b10, 1'b0, 32'h0000_0102, 32'h0, lat, rd, err);
    chk("ns_mis_latency", lat, 1);
    chk("ns_mis_err", {31'b0, err}, 32'h1);
    chk("ns_mis_rdata", rd, 32'h0);
    chk("ns_mis_beats", nbeats, 0);
    do_req(1'b1, 1'b0, 2'b11, 1'b0, 32'h0000_0100, 32'h0, lat, rd, err);
    chk("ns_ill_latency", lat, 1);
    chk("ns_ill_err", {31'b0, err}, 32'h1);
    chk("ns_ill_beats", nbeats, 0);
    do_req(1'b1, 1'b0, 2'b10, 1'b0, 32'h0000_0104, 32'h0, lat, rd, err);
    chk("ns_lw_latency", lat, 2);
    chk("ns_lw_err", {31'b0, err}, 32'h0);
    chk("ns_lw_rdata", rd, 32'h1357_9BDF);
    chk("ns_lw_rd_ctrl", (nbeats > 0) ? {29'b0, bt_rd[0]} : 32'hFFFF_FFFF, 32'h5);
    chk("ns_req_ready", {31'b0, bus_ns.req_ready}, 32'h1);

    // Reset during the third byte beat of a split store.
    bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_size = 2'b10; bus.req_unsigned = 1'b0;
    bus.req_addr = 32'h0000_0401; bus.req_wdata = 32'hA1B2_C3D4;
    @(posedge clk);
    @(negedge clk); bus.req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("abort_pre_addr", bus.data_sram_addr, 32'h0000_0403);
    chk("abort_pre_wr", {30'b0, bus.data_sram_wr_ctrl}, 32'h1);
    rst_n = 1'b0;
    #1;
    chk("abort_wr_ctrl", {30'b0, bus.data_sram_wr_ctrl}, 32'h0);
    chk("abort_addr", bus.data_sram_addr, 32'h0);
    chk("abort_wdata", bus.data_sram_wdata, 32'h0);
    chk("abort_resp_valid", {31'b0, bus.resp_valid}, 32'h0);
    chk("abort_req_ready", {31'b0, bus.req_ready}, 32'h1);
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk($sformatf("abort_no_resp_%0d", c), {31'b0, bus.resp_valid}, 32'h0);
    end
    chk("abort_ready_after", {31'b0, bus.req_ready}, 32'h1);
    do_req(1'b0, 1'b1, 2'b10, 1'b0, 32'h0000_0408, 32'h5566_7788, lat, rd, err);
    chk("post_sw_latency", lat, 2);
    chk("post_sw_err", {31'b0, err}, 32'h0);
    do_req(1'b0, 1'b0, 2'b10, 1'b0, 32'h0000_0400, 32'h0, lat, rd, err);
    chk("abort_partial_lo", rd, 32'h00C3_D400);
    do_req(1'b0, 1'b0, 2'b10, 1'b0, 32'h0000_0404, 32'h0, lat, rd, err);
    chk("abort_partial_hi", rd, 32'h0);
    do_req(1'b0, 1'b0, 2'b10, 1'b0, 32'h0000_0408, 32'h0, lat, rd, err);
    chk("post_sw_readback", rd, 32'h5566_7788);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
